lif_step_scheduler: RTL and testbench
=====================================

LIF_STEP_SCHEDULER -- requirements
Module: lif_step_scheduler

Interface
REQ-001 SHALL have parameter N_NEURONS, default 16: number of time-multiplexed LIF neurons.
REQ-002 SHALL have parameter ID_W, default 4: neuron index width (log2 N_NEURONS).
REQ-003 SHALL have parameter LEAK_SHIFT, default 3: leak is v >> LEAK_SHIFT per timestep.
REQ-004 SHALL have parameter THRESH, default 8'd200: firing threshold.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port stop, input, 1: freeze sequencing while high.
REQ-009 SHALL have port step_start, input, 1: request one timestep over all neurons.
REQ-010 SHALL have port in_valid, input, 1: synaptic event valid.
REQ-011 SHALL have port in_id, input, ID_W: target neuron of the event.
REQ-012 SHALL have port in_weight, input, 8: unsigned event current.
REQ-013 SHALL have port in_ready, output, 1: event accepted when in_valid && in_ready.
REQ-014 SHALL have port spike_valid, output, 1: one-cycle spike pulse.
REQ-015 SHALL have port spike_id, output, ID_W: index of the spiking neuron.
REQ-016 SHALL have port busy, output, 1: high while state != IDLE.
REQ-017 SHALL have port step_done, output, 1: one-cycle end-of-timestep pulse.
REQ-018 SHALL have port rd_id, input, ID_W: debug read index.
REQ-019 SHALL have port rd_v, output, 8: combinational membrane value of neuron rd_id.

Function
REQ-020 SHALL hold per-neuron 8-bit membrane v[k] and 8-bit current buffer i[k].
REQ-021 SHALL drive in_ready = 1 only in IDLE; on accept, i[in_id] <= min(i[in_id] + in_weight, 255) using a 9-bit sum.
REQ-022 SHALL implement FSM states IDLE, PROCESS, DONE.
REQ-023 SHALL transition IDLE->PROCESS on step_start && !stop, with idx <= 0; otherwise step_start is ignored.
REQ-024 SHALL accept an event in the same IDLE cycle as a qualifying step_start and apply it to that step.
REQ-025 SHALL, in PROCESS with stop low, process neuron idx each cycle:
- vl = v - (v >> LEAK_SHIFT)
- vn = min(vl + i[idx], 255), 9-bit sum
- i[idx] <= 0
REQ-026 SHALL, if vn >= THRESH, set v[idx] <= 0 and register spike_valid=1, spike_id=idx in the next cycle; otherwise set v[idx] <= vn.
REQ-027 SHALL, in PROCESS with stop high, hold idx, v and i unchanged and emit no spike.
REQ-028 SHALL increment idx after each processed neuron; after idx = N_NEURONS-1, go to DONE.
REQ-029 SHALL assert step_done for exactly one cycle in DONE, then return to IDLE; DONE is not affected by stop.
REQ-030 SHALL give this latency with stop low: step_start accepted at cycle 0; neuron k processed at cycle k+1; its spike visible at cycle k+2; step_done at cycle N_NEURONS+1.
REQ-031 SHALL ignore step_start while busy, without queuing it.

Reset
REQ-032 SHALL, on reset (including mid-PROCESS): state=IDLE, idx=0, all v[k]=0, all i[k]=0, spike_valid=0, spike_id=0, step_done=0, busy=0.
REQ-033 SHALL have in_ready=1 in the first cycle after reset deasserts.
REQ-034 SHALL give reset priority over all other inputs in the same cycle.

Verification
REQ-035 Reset: assert reset 2 cycles -> busy=0, in_ready=1, spike_valid=0, rd_v=0 for all ids.
REQ-036 Fire: event id=3 weight=250, then step_start -> spike_valid with spike_id=3 at cycle 5, step_done at cycle 17, rd_v(3)=0.
REQ-037 Leak: event id=0 weight=100, then three steps with no further events -> rd_v(0) = 100, 88, 77 after each step; no spikes.
REQ-038 Saturation: three events id=2 weight=100 -> i=255; step -> spike id=2, rd_v(2)=0; i[2]=0 on the next step (no spike).
REQ-039 Stop: stop high for 3 cycles during PROCESS -> idx frozen, no spike pulses while stop high, step_done delayed to cycle 20.
REQ-040 Collisions: step_start during PROCESS -> ignored, exactly one step_done; in_valid during PROCESS -> in_ready=0, i unchanged; reset mid-PROCESS -> IDLE with all state zeroed.

Source files
------------

// File: rtl/lif_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lif_step_scheduler
// Brief    : Time-multiplexed leaky integrate-and-fire neuron array. Synaptic
//            events are buffered per neuron while idle. A timestep then sweeps
//            every neuron once: it applies the leak, integrates the buffered
//            current, and fires or stores the new membrane value.
// Revision : 1.0 - initial release
// ============================================================================
module lif_step_scheduler #(
  parameter int         N_NEURONS  = 16,
  parameter int         ID_W       = 4,
  parameter int         LEAK_SHIFT = 3,
  parameter logic [7:0] THRESH     = 8'd200
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stop,
  input  logic            step_start,
  input  logic            in_valid,
  input  logic [ID_W-1:0] in_id,
  input  logic [7:0]      in_weight,
  output logic            in_ready,
  output logic            spike_valid,
  output logic [ID_W-1:0] spike_id,
  output logic            busy,
  output logic            step_done,
  input  logic [ID_W-1:0] rd_id,
  output logic [7:0]      rd_v
);

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_NEURONS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PROCESS = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_idx;
  logic [7:0]      r_v   [N_NEURONS];
  logic [7:0]      r_cur [N_NEURONS];
  logic            r_spike_valid;
  logic [ID_W-1:0] r_spike_id;

  logic            w_accept;
  logic            w_start;
  logic            w_process;
  logic [8:0]      w_acc_sum;
  logic [7:0]      w_acc_sat;
  logic [7:0]      w_v_cur;
  logic [7:0]      w_i_cur;
  logic [7:0]      w_v_leak;
  logic [8:0]      w_v_sum;
  logic [7:0]      w_v_new;
  logic            w_fire;

  // Handshake and status decode; events are only taken between timesteps.
  assign in_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign step_done   = (r_state == S_DONE);
  assign spike_valid = r_spike_valid;
  assign spike_id    = r_spike_id;
  assign rd_v        = r_v[rd_id];

  assign w_accept  = in_valid && in_ready;
  assign w_start   = (r_state == S_IDLE) && step_start && !stop;
  assign w_process = (r_state == S_PROCESS) && !stop;

  // Event accumulation saturates at full scale instead of wrapping.
  assign w_acc_sum = {1'b0, r_cur[in_id]} + {1'b0, in_weight};
  assign w_acc_sat = w_acc_sum[8] ? 8'hFF : w_acc_sum[7:0];

  // Per-neuron update for the neuron currently selected by the sweep index.
  assign w_v_cur  = r_v[r_idx];
  assign w_i_cur  = r_cur[r_idx];
  assign w_v_leak = w_v_cur - (w_v_cur >> LEAK_SHIFT);
  assign w_v_sum  = {1'b0, w_v_leak} + {1'b0, w_i_cur};
  assign w_v_new  = w_v_sum[8] ? 8'hFF : w_v_sum[7:0];
  assign w_fire   = (w_v_new >= THRESH);

  // Next-state logic; stop freezes the sweep but never the DONE pulse.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_state_nxt = S_PROCESS;
      S_PROCESS: if (w_process && (r_idx == LAST_IDX)) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Sweep index and registered spike output (one cycle after processing).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx         <= '0;
      r_spike_valid <= 1'b0;
      r_spike_id    <= '0;
    end else begin
      r_spike_valid <= 1'b0;
      if (w_start) begin
        r_idx <= '0;
      end else if (w_process) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + ID_W'(1);
        if (w_fire) begin
          r_spike_valid <= 1'b1;
          r_spike_id    <= r_idx;
        end
      end
    end
  end

  // Membrane and current buffers; accept and process never coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        r_v[k]   <= 8'd0;
        r_cur[k] <= 8'd0;
      end
    end else if (w_accept) begin
      r_cur[in_id] <= w_acc_sat;
    end else if (w_process) begin
      r_cur[r_idx] <= 8'd0;
      r_v[r_idx]   <= w_fire ? 8'd0 : w_v_new;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lif_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lif_step_scheduler
// Brief    : Self-checking bench for lif_step_scheduler: table of single-event
//            steps, directed multi-cycle sequences, randomized steps against a
//            whole-timestep reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lif_step_scheduler;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       stop = 1'b0;
  logic       step_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_id = '0;
  logic [7:0] in_weight = '0;
  logic       in_ready;
  logic       spike_valid;
  logic [3:0] spike_id;
  logic       busy;
  logic       step_done;
  logic [3:0] rd_id = '0;
  logic [7:0] rd_v;

  int checks = 0;
  int errors = 0;

  int sp_id[$];
  int sp_cyc[$];
  int done_cyc;

  int mv[N];
  int mi[N];
  int e_id[$];
  int e_cyc[$];

  lif_step_scheduler #(
    .N_NEURONS(16), .ID_W(4), .LEAK_SHIFT(3), .THRESH(8'd200)
  ) dut (
    .clk(clk), .reset(reset), .stop(stop), .step_start(step_start),
    .in_valid(in_valid), .in_id(in_id), .in_weight(in_weight),
    .in_ready(in_ready), .spike_valid(spike_valid), .spike_id(spike_id),
    .busy(busy), .step_done(step_done), .rd_id(rd_id), .rd_v(rd_v)
  );

  always #50 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic read_v(input int id, output int val);
    rd_id = id[3:0];
    #1;
    val = int'(rd_v);
  endtask

  task automatic do_reset();
    reset = 1'b1; stop = 1'b0; step_start = 1'b0; in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < N; k++) begin
      mv[k] = 0;
      mi[k] = 0;
    end
  endtask

  task automatic send_event(input int id, input int w);
    in_valid = 1'b1; in_id = id[3:0]; in_weight = w[7:0];
    tick();
    in_valid = 1'b0;
  endtask

  // Cycle 0 is the step_start cycle; spikes and step_done are logged by cycle.
  task automatic run_step(input logic [63:0] stop_mask, input bit collide);
    sp_id.delete(); sp_cyc.delete(); done_cyc = 0;
    stop = 1'b0; step_start = 1'b1;
    tick();
    step_start = 1'b0;
    for (int c = 1; c < 100; c++) begin
      stop = (c < 64) ? stop_mask[c] : 1'b0;
      if (collide && c == 3) begin
        step_start = 1'b1; in_valid = 1'b1; in_id = 4'd1; in_weight = 8'd250;
        #1;
        chk("in_ready_while_busy", int'(in_ready), 0);
        chk("busy_in_process", int'(busy), 1);
      end else begin
        step_start = 1'b0; in_valid = 1'b0;
      end
      if (spike_valid) begin
        sp_id.push_back(int'(spike_id));
        sp_cyc.push_back(c);
      end
      if (step_done) begin
        done_cyc = c;
        break;
      end
      tick();
    end
    stop = 1'b0; step_start = 1'b0; in_valid = 1'b0;
    if (done_cyc == 0) chk("step_done_timeout", 0, 1);
    tick();
  endtask

  // Whole-timestep model: neuron k is processed on the (k+1)-th non-stalled cycle.
  task automatic model_step(input logic [63:0] mask, output int exp_done);
    int pos[N];
    int zeros;
    int vl, s, vn;
    zeros = 0;
    e_id.delete(); e_cyc.delete();
    for (int c = 1; c < 64 && zeros < N; c++) begin
      if (!mask[c]) begin
        pos[zeros] = c;
        zeros++;
      end
    end
    for (int k = 0; k < N; k++) begin
      vl = mv[k] - mv[k] / 8;
      s  = vl + mi[k];
      vn = (s > 255) ? 255 : s;
      mi[k] = 0;
      if (vn >= 200) begin
        mv[k] = 0;
        e_id.push_back(k);
        e_cyc.push_back(pos[k] + 1);
      end else begin
        mv[k] = vn;
      end
    end
    exp_done = pos[N-1] + 1;
  endtask

  typedef struct {
    int id;
    int weight;
    int exp_spike;
    int exp_v;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int val, exp_done, nsp, cnt;
    logic [63:0] mask;

    vecs[0] = '{id: 3,  weight: 250, exp_spike: 1, exp_v: 0};
    vecs[1] = '{id: 0,  weight: 100, exp_spike: 0, exp_v: 100};
    vecs[2] = '{id: 5,  weight: 199, exp_spike: 0, exp_v: 199};
    vecs[3] = '{id: 7,  weight: 200, exp_spike: 1, exp_v: 0};
    vecs[4] = '{id: 15, weight: 255, exp_spike: 1, exp_v: 0};
    vecs[5] = '{id: 9,  weight: 0,   exp_spike: 0, exp_v: 0};

    // Reset state
    do_reset();
    chk("reset_busy", int'(busy), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_spike_valid", int'(spike_valid), 0);
    chk("reset_step_done", int'(step_done), 0);
    for (int k = 0; k < N; k++) begin
      read_v(k, val);
      chk("reset_rd_v", val, 0);
    end

    // Table of single-event timesteps
    for (int t = 0; t < 6; t++) begin
      do_reset();
      send_event(vecs[t].id, vecs[t].weight);
      run_step(64'd0, 1'b0);
      chk("tbl_spike_count", sp_id.size(), vecs[t].exp_spike);
      if (vecs[t].exp_spike == 1 && sp_id.size() == 1) begin
        chk("tbl_spike_id", sp_id[0], vecs[t].id);
        chk("tbl_spike_cycle", sp_cyc[0], vecs[t].id + 2);
      end
      chk("tbl_step_done_cycle", done_cyc, 17);
      read_v(vecs[t].id, val);
      chk("tbl_rd_v", val, vecs[t].exp_v);
    end

    // Leak over three steps
    do_reset();
    send_event(0, 100);
    nsp = 0;
    for (int s = 0; s < 3; s++) begin
      run_step(64'd0, 1'b0);
      nsp += sp_id.size();
      read_v(0, val);
      chk("leak_rd_v", val, (s == 0) ? 100 : (s == 1) ? 88 : 77);
    end
    chk("leak_no_spikes", nsp, 0);

    // Saturating current buffer
    do_reset();
    send_event(2, 100);
    send_event(2, 100);
    send_event(2, 100);
    run_step(64'd0, 1'b0);
    chk("sat_spike_count", sp_id.size(), 1);
    if (sp_id.size() == 1) chk("sat_spike_id", sp_id[0], 2);
    read_v(2, val);
    chk("sat_rd_v", val, 0);
    run_step(64'd0, 1'b0);
    chk("sat_second_step_spikes", sp_id.size(), 0);
    read_v(2, val);
    chk("sat_second_rd_v", val, 0);

    // Stop held during cycles 4..6 stalls neuron 3
    do_reset();
    send_event(3, 250);
    mask = 64'd0;
    mask[4] = 1'b1; mask[5] = 1'b1; mask[6] = 1'b1;
    run_step(mask, 1'b0);
    chk("stop_spike_count", sp_id.size(), 1);
    if (sp_id.size() == 1) begin
      chk("stop_spike_id", sp_id[0], 3);
      chk("stop_spike_cycle", sp_cyc[0], 8);
    end
    chk("stop_step_done_cycle", done_cyc, 20);

    // step_start and in_valid while busy are ignored
    do_reset();
    run_step(64'd0, 1'b1);
    chk("coll_step_done_cycle", done_cyc, 17);
    chk("coll_spikes", sp_id.size(), 0);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (step_done || busy) cnt++;
      tick();
    end
    chk("coll_no_extra_step", cnt, 0);
    run_step(64'd0, 1'b0);
    chk("coll_i_unchanged", sp_id.size(), 0);

    // Reset in the middle of a sweep
    do_reset();
    for (int k = 0; k < N; k++) send_event(k, 150);
    run_step(64'd0, 1'b0);
    for (int k = 0; k < N; k++) send_event(k, 40);
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    tick(); tick(); tick();
    chk("midreset_busy_before", int'(busy), 1);
    do_reset();
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_in_ready", int'(in_ready), 1);
    chk("midreset_spike_valid", int'(spike_valid), 0);
    cnt = 0;
    for (int k = 0; k < N; k++) begin
      read_v(k, val);
      if (val != 0) cnt++;
    end
    chk("midreset_v_cleared", cnt, 0);
    run_step(64'd0, 1'b0);
    chk("midreset_i_cleared", sp_id.size(), 0);

    // Randomized steps against the reference model
    do_reset();
    for (int it = 0; it < 20; it++) begin
      int nev;
      nev = $urandom_range(0, 6);
      for (int e = 0; e < nev; e++) begin
        int id, w;
        id = $urandom_range(0, N - 1);
        w  = $urandom_range(0, 120);
        send_event(id, w);
        mi[id] = (mi[id] + w > 255) ? 255 : mi[id] + w;
      end
      mask = 64'd0;
      for (int c = 1; c < 25; c++) mask[c] = ($urandom_range(0, 3) == 0);
      model_step(mask, exp_done);
      run_step(mask, 1'b0);
      chk("rnd_step_done_cycle", done_cyc, exp_done);
      chk("rnd_spike_count", sp_id.size(), e_id.size());
      if (sp_id.size() == e_id.size()) begin
        for (int j = 0; j < e_id.size(); j++) begin
          chk("rnd_spike_id", sp_id[j], e_id[j]);
          chk("rnd_spike_cycle", sp_cyc[j], e_cyc[j]);
        end
      end
      for (int k = 0; k < N; k++) begin
        read_v(k, val);
        chk("rnd_rd_v", val, mv[k]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
